// File: rtl/msk_holder_ctrl_pkg.sv
// Shared types and elaboration helpers for the masked holder sequencer.
// Pure definitions: no logic, no latency, no flow control.
package msk_holder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    FULL    = 2'd2,
    REFRESH = 2'd3
  } state_e;

  function automatic int unsigned nstages(input int unsigned bits, input int unsigned rate);
    return bits / rate;
  endfunction

  // A single-stage holder still needs a 1-bit counter to keep port widths legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit rate_divides(input int unsigned bits, input int unsigned rate);
    return (rate > 0) && ((bits % rate) == 0);
  endfunction

endpackage

// File: rtl/msk_holder_word_cnt.sv
// Modulo-N counter with clear (priority) and increment; last_o flags N-1.
// Counts on the clock after inc_i; never stalls, wraps to 0 after N-1.
module msk_holder_word_cnt #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = last_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/msk_holder_seq_ctrl.sv
// Sequencer for the masked holder: load NSTAGES share words, expose, refresh by full rotation.
// out_valid one cycle after last load fire; shifts only on in/rnd handshakes. Option: HOLDER_AUTO_REFRESH_EN.
module msk_holder_seq_ctrl
  import msk_holder_ctrl_pkg::*;
#(
  parameter int unsigned d              = 2,
  parameter int unsigned BITS           = 256,
  parameter int unsigned RFRSH_RATE     = 16,
  parameter int unsigned REFRESH_PERIOD = 64
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         rnd_valid_i,
  output logic         rnd_ready_o,
  input  logic         refresh_req_i,
  output logic         out_valid_o,
  input  logic         out_ack_i,
  output logic [d-1:0] enable_o,
  output logic         fetch_in_o,
  output logic         busy_o
);

  localparam int unsigned NSTAGES = nstages(BITS, RFRSH_RATE);
  localparam int unsigned CW      = cnt_width(NSTAGES);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_LOAD    = LOAD;
  localparam logic [1:0] S_FULL    = FULL;
  localparam logic [1:0] S_REFRESH = REFRESH;

  if (!rate_divides(BITS, RFRSH_RATE)) begin : g_bad_rate
    $error("RFRSH_RATE must divide BITS");
  end
  if (REFRESH_PERIOD < 1) begin : g_bad_period
    $error("REFRESH_PERIOD must be at least 1");
  end

  logic [1:0] state_q, state_d;
  logic       pend_q, pend_d;
  logic       is_idle, is_load, is_full, is_rfrsh;
  logic       load_fire, rfrsh_fire, shift_fire;
  logic       wcnt_last, auto_rfrsh;

  assign is_idle  = (state_q == S_IDLE);
  assign is_load  = (state_q == S_LOAD);
  assign is_full  = (state_q == S_FULL);
  assign is_rfrsh = (state_q == S_REFRESH);

  // Reset is folded in so no word is accepted while the holder is held in reset.
  assign in_ready_o  = rst_n_i & (is_idle | is_load);
  assign rnd_ready_o = is_rfrsh;
  assign load_fire   = in_valid_i & in_ready_o;
  assign rfrsh_fire  = rnd_valid_i & rnd_ready_o;
  assign shift_fire  = load_fire | rfrsh_fire;

  assign enable_o    = {d{shift_fire}};
  assign fetch_in_o  = ~is_rfrsh;
  assign busy_o      = is_load | is_rfrsh;
  assign out_valid_o = is_full;

  // Shared between loading and refreshing; it is back at 0 whenever FULL is reached.
  msk_holder_word_cnt #(
    .N(NSTAGES),
    .W(CW)
  ) u_word_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (1'b0),
    .inc_i  (shift_fire),
    .last_o (wcnt_last)
  );

`ifdef HOLDER_AUTO_REFRESH_EN
  localparam int unsigned PW = cnt_width(REFRESH_PERIOD);
  logic per_last;

  msk_holder_word_cnt #(
    .N(REFRESH_PERIOD),
    .W(PW)
  ) u_period_cnt (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .clr_i  (~is_full),
    .inc_i  (is_full),
    .last_o (per_last)
  );

  assign auto_rfrsh = is_full & per_last;
`else
  assign auto_rfrsh = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (load_fire) state_d = wcnt_last ? S_FULL : S_LOAD;
      end
      S_LOAD: begin
        if (refresh_req_i) pend_d = 1'b1;
        if (load_fire && wcnt_last) state_d = S_FULL;
      end
      S_FULL: begin
        pend_d = 1'b0;
        if (out_ack_i) begin
          state_d = S_IDLE;
        end else if (refresh_req_i || pend_q || auto_rfrsh) begin
          state_d = S_REFRESH;
        end
      end
      S_REFRESH: begin
        if (refresh_req_i) pend_d = 1'b1;
        if (rfrsh_fire && wcnt_last) state_d = S_FULL;
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_msk_holder_seq_ctrl.sv
// Bench: sequencer driving a behavioural 2-share holder; occupancy-level model checked every cycle.
module tb_msk_holder_seq_ctrl;

  localparam int D      = 2;
  localparam int BITS   = 32;
  localparam int RATE   = 8;
  localparam int NS     = BITS / RATE;
  localparam int PERIOD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, rnd_valid = 1'b0, refresh_req = 1'b0, out_ack = 1'b0;
  logic in_ready, rnd_ready, out_valid, fetch_in, busy;
  logic [D-1:0] enable;

  logic [D-1:0][RATE-1:0] sh_in = '0;
  logic [RATE-1:0]        rnd_word = '0;
  logic [D-1:0][BITS-1:0] holder;

  int total = 0;
  int bad = 0;
  int n_ld = 0;
  int n_rf = 0;

  always #5 clk = ~clk;

  msk_holder_seq_ctrl #(
    .d(D), .BITS(BITS), .RFRSH_RATE(RATE), .REFRESH_PERIOD(PERIOD)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .rnd_valid_i(rnd_valid), .rnd_ready_o(rnd_ready),
    .refresh_req_i(refresh_req),
    .out_valid_o(out_valid), .out_ack_i(out_ack),
    .enable_o(enable), .fetch_in_o(fetch_in), .busy_o(busy)
  );

  // Holder: circular right shift, new word enters at the top; refresh re-enters the bottom word xor rnd.
  always @(posedge clk) begin
    for (int s = 0; s < D; s++) begin
      if (enable[s]) begin
        holder[s] <= {(fetch_in ? sh_in[s] : (holder[s][RATE-1:0] ^ rnd_word)), holder[s][BITS-1:RATE]};
      end
    end
  end

  function automatic logic [BITS-1:0] unmask();
    return holder[0] ^ holder[1];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && enable == 2'b11) begin
      if (fetch_in) n_ld++;
      else n_rf++;
    end
  end

  // Model: words held, refresh shifts still owed, pending request, cycles spent exposed.
  int m_filled = 0, m_rot = 0, m_age = 0;
  bit m_pend = 1'b0;

  initial begin : model_proc
    bit lf, rf, fl, bz, go_rf, auto_r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        fl = (m_filled == NS) && (m_rot == 0);
        lf = (m_filled < NS) && in_valid;
        rf = (m_rot > 0) && rnd_valid;
        bz = (m_filled > 0 && m_filled < NS) || (m_rot > 0);
        check("in_ready",  32'(in_ready),  32'(m_filled < NS));
        check("rnd_ready", 32'(rnd_ready), 32'(m_rot > 0));
        check("out_valid", 32'(out_valid), 32'(fl));
        check("busy",      32'(busy),      32'(bz));
        check("fetch_in",  32'(fetch_in),  32'(m_rot == 0));
        check("enable",    32'(enable),    (lf || rf) ? 32'h3 : 32'h0);
      end
      @(posedge clk);
      if (!rst_n) begin
        m_filled = 0; m_rot = 0; m_age = 0; m_pend = 1'b0;
      end else begin
        fl = (m_filled == NS) && (m_rot == 0);
        lf = (m_filled < NS) && in_valid;
        rf = (m_rot > 0) && rnd_valid;
        bz = (m_filled > 0 && m_filled < NS) || (m_rot > 0);
        auto_r = 1'b0;
`ifdef HOLDER_AUTO_REFRESH_EN
        auto_r = (m_age == PERIOD - 1);
`endif
        go_rf = fl && !out_ack && (refresh_req || m_pend || auto_r);
        if (lf) m_filled++;
        if (rf) m_rot--;
        if (fl && out_ack) begin
          m_filled = 0; m_pend = 1'b0;
        end else if (go_rf) begin
          m_rot = NS; m_pend = 1'b0;
        end else if (bz && refresh_req) begin
          m_pend = 1'b1;
        end
        m_age = (fl && !out_ack && !go_rf) ? m_age + 1 : 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [7:0] w, input logic v);
    logic [7:0] m;
    m = 8'($urandom);
    sh_in[0] = w ^ m;
    sh_in[1] = m;
    in_valid = v;
    step();
  endtask

  task automatic load4(input logic [31:0] val);
    logic [31:0] v;
    v = val;
    for (int i = 0; i < NS; i++) put_word(v[8*i +: 8], 1'b1);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  initial begin : stim
    int base, cyc, wi;
    logic [31:0] u;
    logic [BITS-1:0] s0;
    logic [6:0] gap_pat;
    logic [5:0] rnd_pat;
    logic [31:0] words;

    // Reset state, with in_valid up to show nothing is accepted
    in_valid = 1'b1;
    #12;
    check("rst in_ready", 32'(in_ready), 32'h0);
    check("rst enable", 32'(enable), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst rnd_ready", 32'(rnd_ready), 32'h0);
    check("rst fetch_in", 32'(fetch_in), 32'h1);
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    #1;
    check("idle in_ready", 32'(in_ready), 32'h1);

    // Back-to-back load
    base = n_ld;
    load4(32'hD4C3B2A1);
    check("b2b out_valid", 32'(out_valid), 32'h1);
    check("b2b enables", 32'(n_ld - base), 32'd4);
    check("b2b unmasked", unmask(), 32'hD4C3B2A1);
    ack();
    #1;
    check("ack to idle", 32'(in_ready & ~out_valid), 32'h1);

    // Stray request and ack in IDLE: ignored
    refresh_req = 1'b1; out_ack = 1'b1;
    step();
    refresh_req = 1'b0; out_ack = 1'b0;
    step();

    // Load with in_valid gaps
    base = n_ld;
    gap_pat = 7'b1011001;
    words = 32'hD4C3B2A1;
    wi = 0;
    for (int i = 0; i < 7; i++) begin
      put_word(words[8*wi +: 8], gap_pat[i]);
      if (gap_pat[i]) wi++;
    end
    in_valid = 1'b0;
    #1;
    check("gap out_valid", 32'(out_valid), 32'h1);
    check("gap enables", 32'(n_ld - base), 32'd4);
    check("gap unmasked", unmask(), 32'hD4C3B2A1);

    // Refresh rotation with rnd_valid stalls
    base = n_rf;
    s0 = holder[0];
    u = unmask();
    refresh_req = 1'b1;
    step();
    refresh_req = 1'b0;
    #1;
    check("rf started", 32'(rnd_ready), 32'h1);
    rnd_pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      rnd_valid = rnd_pat[i];
      rnd_word = 8'($urandom_range(1, 255));
      step();
    end
    rnd_valid = 1'b0;
    #1;
    check("rf done out_valid", 32'(out_valid), 32'h1);
    check("rf enables", 32'(n_rf - base), 32'd4);
    check("rf unmasked", unmask(), u);
    check("rf shares changed", 32'(holder[0] != s0), 32'h1);

    // Ack and request together: ack wins
    base = n_rf;
    out_ack = 1'b1; refresh_req = 1'b1;
    step();
    out_ack = 1'b0; refresh_req = 1'b0;
    #1;
    check("ack+req out_valid", 32'(out_valid), 32'h0);
    check("ack+req rnd_ready", 32'(rnd_ready), 32'h0);
    step(); step();
    load4(32'h0F1E2D3C);
    step(); step(); step();
    check("no pending rf", 32'(n_rf - base), 32'd0);
    check("no pending unmasked", unmask(), 32'h0F1E2D3C);

    // Request during LOAD: one exposed cycle, then refresh
    ack();
    put_word(8'h01, 1'b1);
    put_word(8'h02, 1'b1);
    refresh_req = 1'b1; in_valid = 1'b0;
    step();
    refresh_req = 1'b0;
    put_word(8'h03, 1'b1);
    put_word(8'h04, 1'b1);
    in_valid = 1'b0;
    #1;
    check("pend full cycle", 32'(out_valid), 32'h1);
    step();
    check("pend to refresh", 32'(rnd_ready), 32'h1);
    rnd_valid = 1'b1;
    for (int i = 0; i < NS; i++) begin
      rnd_word = 8'($urandom_range(1, 255));
      step();
    end
    rnd_valid = 1'b0;
    #1;
    check("pend rf done", 32'(out_valid), 32'h1);
    check("pend unmasked", unmask(), 32'h04030201);

    // Asynchronous reset mid-refresh
    ack();
    load4(32'h55AA55AA);
    refresh_req = 1'b1;
    step();
    refresh_req = 1'b0;
    rnd_valid = 1'b1;
    rnd_word = 8'h5A;
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    check("arst rnd_ready", 32'(rnd_ready), 32'h0);
    check("arst enable", 32'(enable), 32'h0);
    check("arst fetch_in", 32'(fetch_in), 32'h1);
    check("arst busy", 32'(busy), 32'h0);
    check("arst in_ready", 32'(in_ready), 32'h0);
    rnd_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    load4(32'h44332211);
    check("post-rst out_valid", 32'(out_valid), 32'h1);
    check("post-rst unmasked", unmask(), 32'h44332211);

`ifdef HOLDER_AUTO_REFRESH_EN
    // Automatic refresh after PERIOD exposed cycles, repeating
    rnd_valid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      while (out_valid && cyc < 40) begin
        cyc++;
        step();
      end
      check("auto period", 32'(cyc), 32'(PERIOD));
      check("auto rnd_ready", 32'(rnd_ready), 32'h1);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
        cyc++;
        step();
      end
      check("auto rotation", 32'(cyc), 32'(NS));
    end
    rnd_valid = 1'b0;
    check("auto unmasked", unmask(), 32'h44332211);
`else
    // Without automatic refresh the holder stays exposed
    base = n_rf;
    rnd_valid = 1'b1;
    cyc = 0;
    while (out_valid && cyc < 3 * PERIOD) begin
      cyc++;
      step();
    end
    rnd_valid = 1'b0;
    check("full persists", 32'(cyc), 32'(3 * PERIOD));
    check("no auto rf", 32'(n_rf - base), 32'd0);
`endif

    ack();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
